// File: rtl/q3b_x_serializer.sv
// Serializes W-bit words LSB-first onto x and runs a shadow copy of the q3b receiver FSM.
// z_pred tracks the receiver's z cycle-for-cycle, and ones_cnt reports the z=1 results per word.
//   state | meaning
//   IDLE  | line idle (x=0), ready to accept a word
//   SHIFT | driving one data bit per cycle, LSB first
module q3b_x_serializer #(
    parameter int W  = 8,
    parameter int CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          x,
    output logic          x_active,
    output logic          z_pred,
    output logic          done,
    output logic [CW-1:0] ones_cnt
);

    typedef enum logic {IDLE, SHIFT} ctl_t;

    ctl_t          state, state_nx;
    logic [W-1:0]  shreg, shreg_nx;
    logic [CW-1:0] bit_cnt, bit_cnt_nx;
    logic [CW-1:0] run_cnt, run_cnt_nx;
    logic [CW-1:0] ones_nx;
    logic [2:0]    sh, sh_nx;
    logic          x_nx, xa_nx, done_nx;

    function automatic logic [2:0] shadow_next(input logic [2:0] s, input logic b);
        case (s)
            3'b000:  return b ? 3'b001 : 3'b000;
            3'b001:  return b ? 3'b100 : 3'b001;
            3'b010:  return b ? 3'b001 : 3'b010;
            3'b011:  return b ? 3'b010 : 3'b001;
            3'b100:  return b ? 3'b100 : 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic z_of(input logic [2:0] s);
        return (s == 3'b011) || (s == 3'b100);
    endfunction

    always_comb begin
        state_nx   = state;
        shreg_nx   = shreg;
        bit_cnt_nx = bit_cnt;
        run_cnt_nx = run_cnt;
        ones_nx    = ones_cnt;
        x_nx       = x;
        xa_nx      = x_active;
        done_nx    = 1'b0;
        in_ready   = (state == IDLE);
        // The shadow sees every x value the receiver sees, idle zeros included.
        sh_nx      = shadow_next(sh, x);
        case (state)
            IDLE: begin
                x_nx  = 1'b0;
                xa_nx = 1'b0;
                if (in_valid) begin
                    shreg_nx   = in_data;
                    bit_cnt_nx = CW'(W - 1);
                    run_cnt_nx = '0;
                    x_nx       = in_data[0];
                    xa_nx      = 1'b1;
                    state_nx   = SHIFT;
                end
            end
            SHIFT: begin
                run_cnt_nx = run_cnt + CW'(z_of(sh_nx));
                if (bit_cnt == '0) begin
                    state_nx = IDLE;
                    x_nx     = 1'b0;
                    xa_nx    = 1'b0;
                    done_nx  = 1'b1;
                    ones_nx  = run_cnt_nx;
                end else begin
                    bit_cnt_nx = bit_cnt - 1'b1;
                    shreg_nx   = shreg >> 1;
                    x_nx       = shreg[1];
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            run_cnt  <= '0;
            ones_cnt <= '0;
            sh       <= 3'b000;
            x        <= 1'b0;
            x_active <= 1'b0;
            z_pred   <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            shreg    <= shreg_nx;
            bit_cnt  <= bit_cnt_nx;
            run_cnt  <= run_cnt_nx;
            ones_cnt <= ones_nx;
            sh       <= sh_nx;
            x        <= x_nx;
            x_active <= xa_nx;
            z_pred   <= z_of(sh_nx);
            done     <= done_nx;
        end
    end

endmodule

// File: tb/tb_q3b_x_serializer.sv
// Testbench for q3b_x_serializer: directed scenarios plus randomized traffic
// checked against a bit-queue serializer model feeding a table-driven receiver model.
module tb_q3b_x_serializer;
    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          reset, in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready, x, x_active, z_pred, done;
    logic [CW-1:0] ones_cnt;

    q3b_x_serializer #(.W(W), .CW(CW)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .x(x), .x_active(x_active), .z_pred(z_pred),
        .done(done), .ones_cnt(ones_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // receiver model: next-state table indexed [state][x]
    int   rx_tbl [8][2];
    int   rx;
    logic m_x, m_active, m_done;
    int   m_ones, m_cnt;
    logic q[$];

    function automatic logic zof(input int s);
        return (s == 3) || (s == 4);
    endfunction

    task automatic tick(input logic r, input logic v, input logic [W-1:0] d);
        int nrx;
        reset = r; in_valid = v; in_data = d;
        @(posedge clk);
        if (r) begin
            rx = 0; q.delete(); m_x = 0; m_active = 0; m_done = 0; m_ones = 0; m_cnt = 0;
        end else begin
            nrx = rx_tbl[rx][m_x];
            if (m_active) begin
                m_cnt += int'(zof(nrx));
                if (q.size() == 0) begin
                    m_done = 1; m_ones = m_cnt; m_x = 0; m_active = 0;
                end else begin
                    m_done = 0; m_x = q.pop_front();
                end
            end else begin
                m_done = 0;
                if (v) begin
                    m_cnt = 0; m_x = d[0]; m_active = 1;
                    for (int i = 1; i < W; i++) q.push_back(d[i]);
                end
            end
            rx = nrx;
        end
        #1;
    endtask

    task automatic test_reset();
        tick(1, 0, '0);
        tick(1, 1, 8'hA5);
        n_checks++;
        if ({x, x_active, z_pred, done, in_ready} !== 5'b00001 || ones_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got x=%b xa=%b z=%b done=%b rdy=%b ones=%0d, want 0 0 0 0 1 0",
                     x, x_active, z_pred, done, in_ready, ones_cnt);
        end
    endtask

    // Sends one word (accepted on the first tick) and checks each bit cycle plus the done cycle.
    task automatic test_word(input string name, input logic [W-1:0] d, input int exp_ones);
        tick(0, 1, d);
        for (int k = 0; k < W; k++) begin
            n_checks++;
            if (x !== d[k] || x_active !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_bit%0d: got x=%b xa=%b rdy=%b done=%b, want x=%b xa=1 rdy=0 done=0",
                         name, k, x, x_active, in_ready, done, d[k]);
            end
            n_checks++;
            if (z_pred !== zof(rx)) begin
                n_fail++;
                $display("FAIL %s_zpred%0d: got %b want %b", name, k, z_pred, zof(rx));
            end
            tick(0, 0, '0);
        end
        n_checks++;
        if (done !== 1'b1 || ones_cnt !== CW'(exp_ones) || x !== 1'b0 || x_active !== 1'b0 ||
            in_ready !== 1'b1 || z_pred !== zof(rx)) begin
            n_fail++;
            $display("FAIL %s_done: got done=%b ones=%0d x=%b xa=%b rdy=%b z=%b, want done=1 ones=%0d x=0 xa=0 rdy=1 z=%b",
                     name, done, ones_cnt, x, x_active, in_ready, z_pred, exp_ones, zof(rx));
        end
    endtask

    task automatic test_directed();
        tick(1, 0, '0);
        test_word("w00", 8'h00, 0);
        tick(1, 0, '0);
        test_word("wFF", 8'hFF, 7);
        tick(1, 0, '0);
        test_word("w03", 8'h03, 2);
        tick(0, 0, '0);
        n_checks++;
        if (z_pred !== 1'b0 || done !== 1'b0 || rx != 1) begin
            n_fail++;
            $display("FAIL w03_idle: got z=%b done=%b model_state=%0d, want z=0 done=0 state=1",
                     z_pred, done, rx);
        end
    endtask

    task automatic test_back_to_back();
        tick(1, 0, '0);
        test_word("w0B", 8'h0B, 2);
        test_word("w01_b2b", 8'h01, 0);
    endtask

    task automatic test_reset_mid();
        tick(1, 0, '0);
        tick(0, 1, 8'hFF);
        for (int k = 0; k < 4; k++) tick(0, 1, '0);
        n_checks++;
        if (x !== 1'b1 || x_active !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_bit4: got x=%b xa=%b want 1 1", x, x_active);
        end
        tick(1, 0, '0);
        n_checks++;
        if ({x, x_active, z_pred, done, in_ready} !== 5'b00001 || ones_cnt !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got x=%b xa=%b z=%b done=%b rdy=%b ones=%0d, want 0 0 0 0 1 0",
                     x, x_active, z_pred, done, in_ready, ones_cnt);
        end
        tick(0, 0, '0);
        n_checks++;
        if (done !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_nodone: got done=%b rdy=%b want 0 1", done, in_ready);
        end
        test_word("w00_after", 8'h00, 0);
    endtask

    task automatic test_random();
        logic r, v;
        logic [W-1:0] d;
        for (int c = 0; c < 4000; c++) begin
            r = ($urandom_range(63) == 0);
            v = ($urandom_range(3) != 0);
            d = W'($urandom);
            tick(r, v, d);
            n_checks++;
            if (x !== m_x || x_active !== m_active || in_ready !== !m_active || done !== m_done) begin
                n_fail++;
                $display("FAIL rnd_ctl c=%0d: got x=%b xa=%b rdy=%b done=%b, want %b %b %b %b",
                         c, x, x_active, in_ready, done, m_x, m_active, !m_active, m_done);
            end
            n_checks++;
            if (z_pred !== zof(rx)) begin
                n_fail++;
                $display("FAIL rnd_zpred c=%0d: got %b want %b", c, z_pred, zof(rx));
            end
            n_checks++;
            if (ones_cnt !== CW'(m_ones)) begin
                n_fail++;
                $display("FAIL rnd_ones c=%0d: got %0d want %0d", c, ones_cnt, m_ones);
            end
        end
    endtask

    initial begin
        for (int s = 0; s < 8; s++) begin
            rx_tbl[s][0] = 0;
            rx_tbl[s][1] = 0;
        end
        rx_tbl[0][0] = 0; rx_tbl[0][1] = 1;
        rx_tbl[1][0] = 1; rx_tbl[1][1] = 4;
        rx_tbl[2][0] = 2; rx_tbl[2][1] = 1;
        rx_tbl[3][0] = 1; rx_tbl[3][1] = 2;
        rx_tbl[4][0] = 3; rx_tbl[4][1] = 4;
        rx = 0; m_x = 0; m_active = 0; m_done = 0; m_ones = 0; m_cnt = 0;
        reset = 1; in_valid = 0; in_data = '0;
        #1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
